// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory slave with RV32I load/store sizing
// and a fixed request-to-response latency.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   req_valid/ready     request handshake (ready only while idle)
//   req_write           1 = store, 0 = load
//   req_addr            byte address
//   req_wdata           right-aligned store data
//   req_funct3          RV32I size/sign code
//   resp_valid/ready    response handshake
//   resp_rdata          sign/zero-extended load data (0 for stores and errors)
//   resp_err            misaligned, out-of-range or illegal funct3
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a request; req_ready=1
// ST_WAIT | request latched, latency down-counter running
// ST_RESP | response held on the outputs until resp_ready

module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_funct3,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic             cur_write;
   logic [31:0]      cur_addr;
   logic [31:0]      cur_wdata;
   logic [2:0]       cur_funct3;
   logic             bad;
   logic [IDX_W-1:0] idx;
   logic [31:0]      word;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      ld_data;
   logic [31:0]      st_data;
   logic [3:0]       st_mask;
   logic             enter_resp;
   logic             mem_we;

   // With LATENCY=1 the response is produced on the acceptance edge itself,
   // so the decode has to look at the live request while idle.
   always_comb begin
      if (state_q == ST_IDLE) begin
         cur_write  = req_write;
         cur_addr   = req_addr;
         cur_wdata  = req_wdata;
         cur_funct3 = req_funct3;
      end else begin
         cur_write  = write_q;
         cur_addr   = addr_q;
         cur_wdata  = wdata_q;
         cur_funct3 = funct3_q;
      end
   end

   always_comb begin
      case (cur_funct3)
         3'b000, 3'b001, 3'b010: bad = 1'b0;
         3'b100, 3'b101:         bad = cur_write;
         default:                bad = 1'b1;
      endcase
      if (cur_funct3[1:0] == 2'b01 && cur_addr[0])
         bad = 1'b1;
      if (cur_funct3[1:0] == 2'b10 && cur_addr[1:0] != 2'b00)
         bad = 1'b1;
      if ({2'b00, cur_addr[31:2]} >= 32'(DEPTH_WORDS))
         bad = 1'b1;
   end

   always_comb begin
      idx  = cur_addr[IDX_W+1:2];
      word = bad ? 32'h0 : mem[idx];

      case (cur_addr[1:0])
         2'd0:    ld_byte = word[7:0];
         2'd1:    ld_byte = word[15:8];
         2'd2:    ld_byte = word[23:16];
         default: ld_byte = word[31:24];
      endcase
      ld_half = cur_addr[1] ? word[31:16] : word[15:0];

      // funct3[2] marks the unsigned load variants.
      case (cur_funct3[1:0])
         2'b00:   ld_data = {{24{ld_byte[7] & ~cur_funct3[2]}}, ld_byte};
         2'b01:   ld_data = {{16{ld_half[15] & ~cur_funct3[2]}}, ld_half};
         default: ld_data = word;
      endcase

      case (cur_funct3[1:0])
         2'b00: begin
            st_data = {4{cur_wdata[7:0]}};
            st_mask = 4'b0001 << cur_addr[1:0];
         end
         2'b01: begin
            st_data = {2{cur_wdata[15:0]}};
            st_mask = cur_addr[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            st_data = cur_wdata;
            st_mask = 4'b1111;
         end
      endcase
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      write_d    = write_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      funct3_d   = funct3_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      enter_resp = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               write_d  = req_write;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               funct3_d = req_funct3;
               if (LATENCY == 1) begin
                  state_d    = ST_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_d = ST_WAIT;
                  cnt_d   = 4'(LATENCY - 1);
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d    = ST_RESP;
               enter_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (resp_ready)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (enter_resp) begin
         err_d   = bad;
         rdata_d = (bad || cur_write) ? 32'h0 : ld_data;
      end

      mem_we = enter_resp && cur_write && !bad;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= 4'd0;
         write_q  <= 1'b0;
         addr_q   <= 32'h0;
         wdata_q  <= 32'h0;
         funct3_q <= 3'b000;
         rdata_q  <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         write_q  <= write_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         funct3_q <= funct3_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
      end
   end

   // Storage is deliberately outside the reset domain. A reset during
   // ST_WAIT forces ST_IDLE asynchronously, which drops mem_we.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (st_mask[b])
               mem[idx][8*b +: 8] <= st_data[8*b +: 8];
         end
      end
   end

   assign req_ready  = (state_q == ST_IDLE);
   assign resp_valid = (state_q == ST_RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned DEPTH1 = 16;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f3;
      logic [31:0] er;
      logic        ee;
   } req_t;

   logic        clk;
   logic        rst_n;

   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic [2:0]  req_funct3;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid_1, req_ready_1, req_write_1;
   logic [31:0] req_addr_1, req_wdata_1;
   logic [2:0]  req_funct3_1;
   logic        resp_valid_1, resp_ready_1, resp_err_1;
   logic [31:0] resp_rdata_1;

   exp_t sb_q[$];
   exp_t sb1_q[$];

   int n_checks = 0;
   int n_pass   = 0;

   dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_funct3 (req_funct3),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(DEPTH1), .LATENCY(1)) dut_l1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid_1),
      .req_ready  (req_ready_1),
      .req_write  (req_write_1),
      .req_addr   (req_addr_1),
      .req_wdata  (req_wdata_1),
      .req_funct3 (req_funct3_1),
      .resp_valid (resp_valid_1),
      .resp_ready (resp_ready_1),
      .resp_rdata (resp_rdata_1),
      .resp_err   (resp_err_1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // One transaction on the LATENCY=2 instance. hold>0 keeps resp_ready low
   // for that many cycles in RESP and pulses req_valid partway through.
   task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3, input logic [31:0] er, input logic ee,
                          input int hold, input string nm);
      exp_t e;
      int   lat;
      sb_q.push_back('{er, ee});
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_addr   = a;
      req_wdata  = d;
      req_funct3 = f3;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL %s req_ready before accept: got %b want 1", nm, req_ready);
      else n_pass++;
      @(posedge clk);
      #1;
      // Scramble the request after acceptance; the DUT must use latched values.
      req_valid  = 1'b0;
      req_write  = ~w;
      req_addr   = ~a;
      req_wdata  = ~d;
      req_funct3 = 3'b111;
      lat = 0;
      while (resp_valid !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_checks++;
      if (lat != 2) $display("FAIL %s latency: got %0d cycles want 2", nm, lat);
      else n_pass++;
      if (resp_valid !== 1'b1) begin
         void'(sb_q.pop_front());
         return;
      end
      e = sb_q.pop_front();
      n_checks++;
      if (resp_rdata !== e.rdata) $display("FAIL %s rdata: got %h want %h", nm, resp_rdata, e.rdata);
      else n_pass++;
      n_checks++;
      if (resp_err !== e.err) $display("FAIL %s err: got %b want %b", nm, resp_err, e.err);
      else n_pass++;
      for (int i = 0; i < hold; i++) begin
         if (i == 2) begin
            req_valid  = 1'b1;
            req_write  = 1'b1;
            req_addr   = 32'h10;
            req_wdata  = 32'h0;
            req_funct3 = 3'b010;
         end
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         n_checks++;
         if (resp_valid !== 1'b1 || resp_rdata !== e.rdata || resp_err !== e.err || req_ready !== 1'b0)
            $display("FAIL %s stall cycle %0d: valid=%b rdata=%h err=%b ready=%b want 1 %h %b 0",
                     nm, i, resp_valid, resp_rdata, resp_err, req_ready, e.rdata, e.err);
         else n_pass++;
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      n_checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1)
         $display("FAIL %s release: valid=%b ready=%b want 0 1", nm, resp_valid, req_ready);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      req_valid    = 1'b0;
      req_write    = 1'b0;
      req_addr     = 32'h0;
      req_wdata    = 32'h0;
      req_funct3   = 3'b000;
      resp_ready   = 1'b0;
      req_valid_1  = 1'b0;
      req_write_1  = 1'b0;
      req_addr_1   = 32'h0;
      req_wdata_1  = 32'h0;
      req_funct3_1 = 3'b000;
      resp_ready_1 = 1'b1;
      #2;
      n_checks++;
      if (req_ready !== 1'b1) $display("FAIL reset req_ready: got %b want 1", req_ready);
      else n_pass++;
      n_checks++;
      if (resp_valid !== 1'b0) $display("FAIL reset resp_valid: got %b want 0", resp_valid);
      else n_pass++;
      n_checks++;
      if (resp_rdata !== 32'h0) $display("FAIL reset resp_rdata: got %h want 0", resp_rdata);
      else n_pass++;
      n_checks++;
      if (resp_err !== 1'b0) $display("FAIL reset resp_err: got %b want 0", resp_err);
      else n_pass++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_idle_resp_ready();
      @(negedge clk);
      resp_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL idle_resp_ready cycle %0d: valid=%b ready=%b want 0 1", i, resp_valid, req_ready);
         else n_pass++;
      end
      resp_ready = 1'b0;
   endtask

   task automatic test_word();
      run_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, 32'h0, 1'b0, 0, "sw_10");
      run_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEADBEEF, 1'b0, 0, "lw_10");
   endtask

   task automatic test_subword();
      run_req(1'b1, 32'h11, 32'h00000080, 3'b000, 32'h0, 1'b0, 0, "sb_11");
      run_req(1'b0, 32'h11, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 0, "lb_11");
      run_req(1'b0, 32'h11, 32'h0, 3'b100, 32'h00000080, 1'b0, 0, "lbu_11");
      run_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 0, "lw_10_after_sb");
      run_req(1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFFDEAD, 1'b0, 0, "lh_12");
      run_req(1'b0, 32'h12, 32'h0, 3'b101, 32'h0000DEAD, 1'b0, 0, "lhu_12");
      run_req(1'b0, 32'h10, 32'h0, 3'b000, 32'hFFFFFFEF, 1'b0, 0, "lb_10");
      run_req(1'b1, 32'h14, 32'h00000000, 3'b010, 32'h0, 1'b0, 0, "sw_14");
      run_req(1'b1, 32'h16, 32'h5555ABCD, 3'b001, 32'h0, 1'b0, 0, "sh_16");
      run_req(1'b0, 32'h14, 32'h0, 3'b010, 32'hABCD0000, 1'b0, 0, "lw_14");
   endtask

   task automatic test_errors();
      run_req(1'b0, 32'h13, 32'h0, 3'b001, 32'h0, 1'b1, 0, "lh_13_misaligned");
      run_req(1'b1, 32'h12, 32'h55555555, 3'b010, 32'h0, 1'b1, 0, "sw_12_misaligned");
      run_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 0, "lw_10_after_bad_sw");
      run_req(1'b0, 4 * DEPTH, 32'h0, 3'b010, 32'h0, 1'b1, 0, "lw_out_of_range");
      run_req(1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1, 0, "load_f3_011");
      run_req(1'b1, 32'h10, 32'h11111111, 3'b100, 32'h0, 1'b1, 0, "store_f3_100");
      run_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 0, "lw_10_after_bad_f3");
   endtask

   task automatic test_stall();
      run_req(1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD80EF, 1'b0, 5, "stall_lw_10");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (resp_valid !== 1'b0 || req_ready !== 1'b1)
            $display("FAIL stall_no_accept cycle %0d: valid=%b ready=%b want 0 1", i, resp_valid, req_ready);
         else n_pass++;
      end
   endtask

   task automatic test_reset_abort();
      run_req(1'b1, 32'h20, 32'hCAFEF00D, 3'b010, 32'h0, 1'b0, 0, "sw_20_prior");
      run_req(1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 0, "lw_20_prior");
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_addr   = 32'h20;
      req_wdata  = 32'h12345678;
      req_funct3 = 3'b010;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      n_checks++;
      if (req_ready !== 1'b0) $display("FAIL abort in_wait req_ready: got %b want 0", req_ready);
      else n_pass++;
      #1;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0)
         $display("FAIL abort async_reset: ready=%b valid=%b rdata=%h err=%b want 1 0 00000000 0",
                  req_ready, resp_valid, resp_rdata, resp_err);
      else n_pass++;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (resp_valid !== 1'b0) $display("FAIL abort no_response cycle %0d: got %b want 0", i, resp_valid);
         else n_pass++;
      end
      run_req(1'b0, 32'h20, 32'h0, 3'b010, 32'hCAFEF00D, 1'b0, 0, "lw_20_after_abort");
   endtask

   task automatic test_back_to_back();
      req_t tbl[8];
      exp_t e;
      int   nreq;
      tbl[0] = '{1'b1, 32'h00, 32'h11111111, 3'b010, 32'h0,        1'b0};
      tbl[1] = '{1'b1, 32'h04, 32'h22222222, 3'b010, 32'h0,        1'b0};
      tbl[2] = '{1'b0, 32'h00, 32'h0,        3'b010, 32'h11111111, 1'b0};
      tbl[3] = '{1'b0, 32'h04, 32'h0,        3'b010, 32'h22222222, 1'b0};
      tbl[4] = '{1'b1, 32'h05, 32'h000000AB, 3'b000, 32'h0,        1'b0};
      tbl[5] = '{1'b0, 32'h05, 32'h0,        3'b100, 32'h000000AB, 1'b0};
      tbl[6] = '{1'b0, 32'h04, 32'h0,        3'b010, 32'h2222AB22, 1'b0};
      tbl[7] = '{1'b0, 4 * DEPTH1, 32'h0,    3'b010, 32'h0,        1'b1};
      nreq = 8;
      resp_ready_1 = 1'b1;
      for (int k = 0; k < 2 * nreq; k++) begin
         @(negedge clk);
         n_checks++;
         if (req_ready_1 !== ((k % 2) == 0) || resp_valid_1 !== ((k % 2) == 1))
            $display("FAIL b2b cycle %0d handshake: ready=%b valid=%b want %b %b",
                     k, req_ready_1, resp_valid_1, (k % 2) == 0, (k % 2) == 1);
         else n_pass++;
         if ((k % 2) == 1 && resp_valid_1 === 1'b1) begin
            if (sb1_q.size() == 0) begin
               n_checks++;
               $display("FAIL b2b cycle %0d: response with empty scoreboard, rdata=%h", k, resp_rdata_1);
            end else begin
               e = sb1_q.pop_front();
               n_checks++;
               if (resp_rdata_1 !== e.rdata || resp_err_1 !== e.err)
                  $display("FAIL b2b resp %0d: rdata=%h err=%b want %h %b",
                           k / 2, resp_rdata_1, resp_err_1, e.rdata, e.err);
               else n_pass++;
            end
         end
         if ((k % 2) == 0) begin
            req_valid_1  = 1'b1;
            req_write_1  = tbl[k/2].w;
            req_addr_1   = tbl[k/2].a;
            req_wdata_1  = tbl[k/2].d;
            req_funct3_1 = tbl[k/2].f3;
            sb1_q.push_back('{tbl[k/2].er, tbl[k/2].ee});
         end else if (k == 2 * nreq - 1) begin
            req_valid_1 = 1'b0;
         end
      end
      n_checks++;
      if (sb1_q.size() != 0) $display("FAIL b2b leftover: got %0d pending want 0", sb1_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_idle_resp_ready();
      test_word();
      test_subword();
      test_errors();
      test_stall();
      test_reset_abort();
      test_back_to_back();
      n_checks++;
      if (sb_q.size() != 0) $display("FAIL scoreboard leftover: got %0d pending want 0", sb_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024: number of 32-bit words of storage.
REQ-002 Parameter LATENCY, default 2, legal range 1..15: cycles from request acceptance to response valid.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  1  requester presents a request.
REQ-006 req_ready  output  1  responder can accept a request this cycle.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-010 req_funct3  input  3  RV32I size/sign code.
REQ-011 resp_valid  output  1  response presented.
REQ-012 resp_ready  input  1  requester accepts response.
REQ-013 resp_rdata  output  32  load result, sign/zero-extended.
REQ-014 resp_err  output  1  request rejected (misaligned, out of range, illegal funct3).

Function
REQ-015 The block SHALL implement three states: IDLE, WAIT, RESP.
REQ-016 The block SHALL drive req_ready=1 only in IDLE, and SHALL drive resp_valid=1 only in RESP.
REQ-017 Acceptance SHALL occur on a rising edge with req_valid=1 and req_ready=1; write, addr, wdata and funct3 SHALL be latched then, and later input changes SHALL be ignored.
REQ-018 On acceptance the block SHALL move IDLE->WAIT and load a down-counter with LATENCY-1; for LATENCY=1 it SHALL go IDLE->RESP directly.
REQ-019 In WAIT the counter SHALL decrement each cycle, and the block SHALL enter RESP on the edge where the counter is 0, so resp_valid rises exactly LATENCY cycles after the acceptance edge.
REQ-020 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until an edge with resp_ready=1; that edge SHALL return the block to IDLE (no back-to-back acceptance on the same edge).
REQ-021 Loads SHALL use funct3 000 LB, 001 LH, 010 LW, 100 LBU and 101 LHU, little-endian, with the byte/half selected by addr[1:0]; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend.
REQ-022 Stores SHALL use funct3 000 SB, 001 SH and 010 SW, and SHALL write only the addressed byte lanes; other lanes SHALL be unchanged.
REQ-023 The storage write SHALL occur on the edge entering RESP; load data SHALL be read from storage state at that same edge.
REQ-024 Errors: half access with addr[0]=1; word access with addr[1:0]!=0; addr[31:2]>=DEPTH_WORDS; any unlisted funct3 (including 011, 110, 111, and 100/101 for stores).
REQ-025 An erroneous request SHALL still complete with full LATENCY, with resp_err=1, resp_rdata=0, and no storage write.
REQ-026 Store responses SHALL have resp_rdata=0, and every successful response SHALL have resp_err=0.
REQ-027 resp_ready asserted outside RESP SHALL have no effect.

Reset
REQ-028 While rst_n=0 the block SHALL be in IDLE with the counter at 0, req_ready=1, resp_valid=0, resp_rdata=0 and resp_err=0, independent of clk.
REQ-029 Reset asserted in WAIT or RESP SHALL abort the in-flight request; a store not yet written SHALL NOT be written, and no response SHALL be emitted after release.
REQ-030 Storage contents SHALL NOT be cleared by reset.

Verification
REQ-031 The bench SHALL cover: SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err=0, resp_valid exactly 2 cycles after each acceptance (LATENCY=2).
REQ-032 The bench SHALL cover: after the above, SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80, LBU 0x11 -> 0x00000080, LW 0x10 -> 0xDEAD80EF.
REQ-033 The bench SHALL cover: LH addr 0x13 -> err=1, rdata=0; SW addr 0x12 -> err=1, after which LW 0x10 is unchanged; LW addr 4*DEPTH_WORDS -> err=1.
REQ-034 The bench SHALL cover: resp_ready held 0 for 5 cycles in RESP -> resp_valid, rdata and err stable; req_ready=0 throughout, and a req_valid pulse meanwhile is not accepted.
REQ-035 The bench SHALL cover: SW 0x20 data 0x12345678 with rst_n pulsed low in WAIT -> outputs reach reset values asynchronously, no response follows, and LW 0x20 returns prior contents.
REQ-036 The bench SHALL cover: with LATENCY=1, back-to-back requests with resp_ready tied 1 -> one response per 2 cycles, req_ready alternating 1/0.
